// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall generator for the EX operand muxes.
// Tracks destination tags of EX/MEM/WB and registers selects alongside ID/EX.
module fwd_hazard_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_use_rs_i,
    input  logic             id_use_rt_i,
    input  logic [REG_W-1:0] id_dst_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             flush_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef struct packed {
        logic             valid;
        logic             regwrite;
        logic             memread;
        logic [REG_W-1:0] dst;
    } ex_tag_t;

    // Past EX only "is this a live register writer" matters, so MEM/WB keep
    // valid&regwrite folded into one bit. The retire latch needs no tag: its
    // select (11) is decided while the producer is still in WB.
    typedef struct packed {
        logic             wr;
        logic [REG_W-1:0] dst;
    } wb_tag_t;

    ex_tag_t ex_q, ex_d;
    wb_tag_t mem_q, mem_d, wb_q;
    logic [1:0][1:0]       sel_q, sel_d, sel_nxt;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [1:0][REG_W-1:0] src;
    logic [1:0]            use_src;
    logic [1:0]            hit_ex, hit_mem, hit_wb;
    logic                  accept;

    assign src     = {id_rt_i, id_rs_i};
    assign use_src = {id_use_rt_i, id_use_rs_i};

    // Operand 0 is rs (fwd_a), operand 1 is rt (fwd_b); $zero never matches.
    for (genvar g = 0; g < 2; g++) begin : g_opnd
        logic nz;
        assign nz         = (src[g] != '0);
        assign hit_ex[g]  = use_src[g] & nz & ex_q.valid & ex_q.regwrite & (ex_q.dst == src[g]);
        assign hit_mem[g] = use_src[g] & nz & mem_q.wr & (mem_q.dst == src[g]);
        assign hit_wb[g]  = use_src[g] & nz & wb_q.wr & (wb_q.dst == src[g]);
        assign sel_d[g]   = hit_ex[g]  ? 2'b01 :
                            hit_mem[g] ? 2'b10 :
                            hit_wb[g]  ? 2'b11 : 2'b00;
    end

    assign stall_o = id_valid_i & ~flush_i & ex_q.memread & (|hit_ex);
    assign accept  = id_valid_i & ~flush_i & ~stall_o;

    always_comb begin
        ex_d      = '0;
        sel_nxt   = '0;
        mem_d.wr  = ex_q.valid & ex_q.regwrite;
        mem_d.dst = ex_q.dst;
        cnt_d     = cnt_q;
        if (accept) begin
            ex_d.valid    = 1'b1;
            ex_d.regwrite = id_regwrite_i;
            ex_d.memread  = id_memread_i;
            ex_d.dst      = id_dst_i;
            sel_nxt       = sel_d;
        end
        if (stall_o && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            sel_q <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= mem_q;
            sel_q <= sel_nxt;
            cnt_q <= cnt_d;
        end
    end

    assign fwd_a_o     = sel_q[0];
    assign fwd_b_o     = sel_q[1];
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed vector bench for fwd_hazard_unit; counter narrowed to 2 bits to reach saturation.
module tb_fwd_hazard_unit;
    localparam int REG_W = 5;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, flush;
    logic [REG_W-1:0] id_rs, id_rt, id_dst;
    logic [1:0]       fwd_a, fwd_b;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    int n_vec = 0;
    int n_bad = 0;

    fwd_hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_dst_i(id_dst),
        .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .flush_i(flush),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .stall_o(stall), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] dst;
        logic       rw, mr, fl;
        logic       e_stall;
        logic [1:0] e_a, e_b;
        int         e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, int rs, int rt, logic urs, logic urt, int dst,
                                logic rw, logic mr, logic fl, logic st, logic [1:0] a,
                                logic [1:0] b, int cnt);
        vec_t t;
        t.v = v; t.rs = rs[4:0]; t.rt = rt[4:0]; t.urs = urs; t.urt = urt; t.dst = dst[4:0];
        t.rw = rw; t.mr = mr; t.fl = fl; t.e_stall = st; t.e_a = a; t.e_b = b; t.e_cnt = cnt;
        return t;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(logic v, int rs, int rt, logic urs, logic urt, int dst,
                         logic rw, logic mr, logic fl);
        id_valid = v; id_rs = rs[4:0]; id_rt = rt[4:0]; id_use_rs = urs; id_use_rt = urt;
        id_dst = dst[4:0]; id_regwrite = rw; id_memread = mr; flush = fl;
    endtask

    // Drive on negedge, check stall before the edge, selects/count after it.
    task automatic apply(vec_t t, string tag);
        @(negedge clk);
        drive(t.v, t.rs, t.rt, t.urs, t.urt, t.dst, t.rw, t.mr, t.fl);
        #1 chk({tag, " stall"}, int'(stall), int'(t.e_stall));
        @(posedge clk);
        #1;
        chk({tag, " fwd_a"}, int'(fwd_a), int'(t.e_a));
        chk({tag, " fwd_b"}, int'(fwd_b), int'(t.e_b));
        chk({tag, " cnt"}, int'(stall_cnt), t.e_cnt);
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst stall", int'(stall), 0);
        chk("rst fwd_a", int'(fwd_a), 0);
        chk("rst fwd_b", int'(fwd_b), 0);
        chk("rst cnt", int'(stall_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        //                 v rs rt urs urt dst rw mr fl  st  a      b     cnt
        tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0)); // add $3
        tbl.push_back(mk(1, 3, 2, 1, 1, 6, 1, 0, 0, 0, 2'b01, 2'b00, 0)); // sub rs=3, dist 1
        tbl.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0)); // writer $5
        tbl.push_back(mk(1, 1, 2, 0, 0, 7, 1, 0, 0, 0, 2'b00, 2'b00, 0)); // unrelated
        tbl.push_back(mk(1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0)); // rt=5 dist 2
        tbl.push_back(mk(1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0)); // rt=5 dist 3
        tbl.push_back(mk(1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0)); // rt=5 dist 4
        tbl.push_back(mk(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 2'b00, 2'b00, 0)); // lw $8
        tbl.push_back(mk(1, 8, 0, 1, 0, 11, 1, 0, 0, 1, 2'b00, 2'b00, 1)); // load-use stall
        tbl.push_back(mk(1, 8, 0, 1, 0, 11, 1, 0, 0, 0, 2'b10, 2'b00, 1)); // re-presented
        tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 2'b00, 2'b00, 1)); // writer $4 (older)
        tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 2'b00, 2'b00, 1)); // writer $4 (younger)
        tbl.push_back(mk(1, 4, 4, 1, 1, 0, 1, 0, 0, 0, 2'b01, 2'b01, 1)); // EX beats MEM; writes $0
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1)); // reads $0
        tbl.push_back(mk(1, 4, 4, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b11, 1)); // use_rs=0 masks
        tbl.push_back(mk(1, 1, 0, 0, 0, 9, 1, 1, 0, 0, 2'b00, 2'b00, 1)); // lw $9
        tbl.push_back(mk(1, 9, 0, 1, 0, 12, 1, 0, 1, 0, 2'b00, 2'b00, 1)); // flushed: no stall
        tbl.push_back(mk(1, 9, 0, 1, 0, 13, 1, 0, 0, 0, 2'b10, 2'b00, 1)); // lw $9 still in MEM
        tbl.push_back(mk(0, 9, 9, 1, 1, 13, 1, 0, 0, 0, 2'b00, 2'b00, 1)); // invalid ID
        tbl.push_back(mk(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 2'b00, 2'b00, 1)); // lw $12
        tbl.push_back(mk(1, 3, 12, 1, 1, 14, 1, 0, 0, 1, 2'b00, 2'b00, 2)); // rt load-use
        tbl.push_back(mk(1, 3, 12, 1, 1, 14, 1, 0, 0, 0, 2'b00, 2'b10, 2)); // re-presented
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2)); // lw $0
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2)); // no stall on $0

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("init stall", int'(stall), 0);
        chk("init fwd_a", int'(fwd_a), 0);
        chk("init fwd_b", int'(fwd_b), 0);
        chk("init cnt", int'(stall_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Mid-stream reset with writers of 13/14/15 in WB/MEM/EX (load in EX).
        apply(mk(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 2'b00, 2'b00, 2), "pre13");
        apply(mk(1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 2'b00, 2'b00, 2), "pre14");
        apply(mk(1, 0, 0, 0, 0, 15, 1, 1, 0, 0, 2'b00, 2'b00, 2), "pre15");
        reset_cycle();
        apply(mk(1, 15, 14, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0), "post15");
        apply(mk(1, 13, 13, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0), "post13");

        // Five load-use pairs against a 2-bit counter.
        for (int k = 1; k <= 5; k++) begin
            int c;
            c = (k < 3) ? k : 3;
            apply(mk(1, 0, 0, 0, 0, 20, 1, 1, 0, 0, 2'b00, 2'b00, (k - 1 < 3) ? k - 1 : 3),
                  $sformatf("sat lw%0d", k));
            apply(mk(1, 20, 0, 1, 0, 21, 1, 0, 0, 1, 2'b00, 2'b00, c), $sformatf("sat stall%0d", k));
            apply(mk(1, 20, 0, 1, 0, 21, 1, 0, 0, 0, 2'b10, 2'b00, c), $sformatf("sat re%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
